// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI output path.
//   - Default 640x480@60 raster timing (pixels / lines).
//   - Bit positions of {vsync,hsync} inside the TMDS control-data word.
//   - State encoding of the video timing controller FSM.
package dvi_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam bit DEF_HSYNC_POL = 1'b0;
   localparam bit DEF_VSYNC_POL = 1'b0;

   // cd = {vsync, hsync}
   localparam int CD_HSYNC = 0;
   localparam int CD_VSYNC = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } dvi_state_t;

endpackage

// File: rtl/tmds_sync_counter.sv
// Single-axis raster counter (horizontal or vertical).
// Region order along the axis: active, front porch, sync, back porch.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     hold the count at 0 (has priority over step)
//   step      advance the count by one position
//   cnt       current position, 0..TOTAL-1
//   wrap      step is set and cnt is at TOTAL-1 (count returns to 0 next)
//   active    cnt lies in the active region
//   sync      cnt lies in the sync window (asserted = 1, no polarity)
module tmds_sync_counter #(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int W      = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         step,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output logic         active,
   output logic         sync
);

   localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
   localparam int SYNC_START = ACTIVE + FP;
   localparam int SYNC_STOP  = ACTIVE + FP + SYNC;   // first position after sync
   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (step) begin
         cnt <= wrap ? '0 : cnt + W'(1);
      end
   end

   assign wrap   = step && (cnt == LAST);
   // Compare in 32 bits so an ACTIVE equal to a power-of-two total cannot truncate.
   assign active = 32'(cnt) < 32'(ACTIVE);
   assign sync   = (32'(cnt) >= 32'(SYNC_START)) && (32'(cnt) < 32'(SYNC_STOP));

endmodule

// File: rtl/tmds_video_timing_ctrl.sv
// Video timing controller feeding the three TMDS channel encoders.
// Generates the raster, fetches pixels from the frame source and drives
// aligned video data, control data and data enable.  Output starts and
// stops only on frame boundaries.
// Ports:
//   pixclk, rst     pixel clock, asynchronous active-high reset
//   enable          request video; acted on only at a frame boundary
//   pix_req         fetch strobe for (pix_x, pix_y); both read 0 when idle
//   pix_rgb         {R,G,B} from the source, valid 1 cycle after pix_req
//   vd_r/vd_g/vd_b  video data to the encoders
//   cd              {vsync,hsync} with polarity applied
//   vde             video data enable
//   frame_start     1-cycle pulse at raster position (0,0) while running
//   busy            high in RUN and DRAIN
//   fsm_state       controller state, for observation
// Pipeline: stage 0 decodes the counters, stage 1 captures the decode
// while the source answers, stage 2 registers all encoder inputs, so every
// output lags its raster position by exactly 2 cycles.
module tmds_video_timing_ctrl
   import dvi_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter bit HSYNC_POL = DEF_HSYNC_POL,
   parameter bit VSYNC_POL = DEF_VSYNC_POL
) (
   input  logic        pixclk,
   input  logic        rst,
   input  logic        enable,
   output logic        pix_req,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   input  logic [23:0] pix_rgb,
   output logic [7:0]  vd_r,
   output logic [7:0]  vd_g,
   output logic [7:0]  vd_b,
   output logic [1:0]  cd,
   output logic        vde,
   output logic        frame_start,
   output logic        busy,
   output dvi_state_t  fsm_state
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   // The encoders reset their running disparity during blanking, so every
   // line needs at least one cycle with vde low.
   if (H_FP + H_SYNC + H_BP < 1) begin : g_blank_check
      $error("tmds_video_timing_ctrl: horizontal blanking must be at least 1 cycle");
   end

   dvi_state_t    state;
   dvi_state_t    state_nx;
   logic          run;
   logic          drain_cnt;
   logic          cnt_clear;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_wrap;
   logic          v_wrap;
   logic          h_act;
   logic          v_act;
   logic          h_sync;
   logic          v_sync;
   logic          active0;
   logic          active_d1;
   logic          hsync_d1;
   logic          vsync_d1;

   // ------------------------------------------------------------------
   // Raster counters; the vertical axis steps on the horizontal wrap.
   // Outside RUN both are held at 0 so a new frame always starts at (0,0).
   // ------------------------------------------------------------------
   assign cnt_clear = !run;

   tmds_sync_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .W      (HW)
   ) u_h_cnt (
      .clk    (pixclk),
      .rst    (rst),
      .clear  (cnt_clear),
      .step   (run),
      .cnt    (h_cnt),
      .wrap   (h_wrap),
      .active (h_act),
      .sync   (h_sync)
   );

   tmds_sync_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .W      (VW)
   ) u_v_cnt (
      .clk    (pixclk),
      .rst    (rst),
      .clear  (cnt_clear),
      .step   (h_wrap),
      .cnt    (v_cnt),
      .wrap   (v_wrap),
      .active (v_act),
      .sync   (v_sync)
   );

   // ------------------------------------------------------------------
   // Controller FSM.  v_wrap is only set on the last cycle of a frame,
   // which is the single point where enable is honoured while running.
   // DRAIN lasts two cycles so the 2-deep pipeline empties before IDLE.
   // ------------------------------------------------------------------
   always_ff @(posedge pixclk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         drain_cnt <= 1'b0;
      end else begin
         state     <= state_nx;
         drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      end
   end

   always_comb begin
      state_nx = state;
      run      = 1'b0;
      busy     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (enable) state_nx = ST_RUN;
         end
         ST_RUN: begin
            run  = 1'b1;
            busy = 1'b1;
            if (v_wrap && !enable) state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (drain_cnt) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign fsm_state = state;

   // ------------------------------------------------------------------
   // Stage 0: fetch request straight from the counters.
   // ------------------------------------------------------------------
   assign active0     = run && h_act && v_act;
   assign pix_req     = active0;
   assign pix_x       = active0 ? 10'(h_cnt) : 10'd0;
   assign pix_y       = active0 ? 10'(v_cnt) : 10'd0;
   assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);

   // ------------------------------------------------------------------
   // Stages 1 and 2.  Decode flags wait one cycle alongside the source
   // latency, then everything is captured into the output registers.
   // Syncs are gated by RUN so IDLE and DRAIN push inactive levels.
   // ------------------------------------------------------------------
   always_ff @(posedge pixclk or posedge rst) begin
      if (rst) begin
         active_d1 <= 1'b0;
         hsync_d1  <= 1'b0;
         vsync_d1  <= 1'b0;
         vde       <= 1'b0;
         vd_r      <= 8'd0;
         vd_g      <= 8'd0;
         vd_b      <= 8'd0;
         cd[CD_HSYNC] <= ~HSYNC_POL;
         cd[CD_VSYNC] <= ~VSYNC_POL;
      end else begin
         active_d1 <= active0;
         hsync_d1  <= run && h_sync;
         vsync_d1  <= run && v_sync;
         vde       <= active_d1;
         {vd_r, vd_g, vd_b} <= active_d1 ? pix_rgb : 24'd0;
         cd[CD_HSYNC] <= hsync_d1 ? HSYNC_POL : ~HSYNC_POL;
         cd[CD_VSYNC] <= vsync_d1 ? VSYNC_POL : ~VSYNC_POL;
      end
   end

endmodule

// File: tb/tb_tmds_video_timing_ctrl.sv
// Bench for tmds_video_timing_ctrl with three instances:
//   u_main  : small raster (24x12), randomized enable, reference model
//   u_tiny  : 8x6 raster with active-high syncs, vector table
//   u_def   : default 640x480 timing, first two lines measured
module tb_tmds_video_timing_ctrl;
   import dvi_pkg::*;

   localparam int M_HA = 16, M_HFP = 2, M_HS = 3, M_HBP = 3;
   localparam int M_VA = 8,  M_VFP = 1, M_VS = 2, M_VBP = 1;
   localparam int M_HT = M_HA + M_HFP + M_HS + M_HBP;
   localparam int M_VT = M_VA + M_VFP + M_VS + M_VBP;
   localparam int M_FT = M_HT * M_VT;

   // ---------------- clock / reset ----------------
   logic pixclk = 1'b0;
   logic rst    = 1'b1;
   always #5 pixclk = ~pixclk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance signals ----------------
   logic m_en = 1'b0, m_req, m_fs, m_vde, m_busy;
   logic [9:0] m_x, m_y;
   logic [23:0] m_rgb = '0;
   logic [7:0] m_r, m_g, m_b;
   logic [1:0] m_cd;
   dvi_state_t m_st;

   logic t_en = 1'b0, t_req, t_fs, t_vde, t_busy;
   logic [9:0] t_x, t_y;
   logic [23:0] t_rgb = '0;
   logic [7:0] t_r, t_g, t_b;
   logic [1:0] t_cd;
   dvi_state_t t_st;

   logic d_en = 1'b0, d_req, d_fs, d_vde, d_busy;
   logic [9:0] d_x, d_y;
   logic [23:0] d_rgb = '0;
   logic [7:0] d_r, d_g, d_b;
   logic [1:0] d_cd;
   dvi_state_t d_st;

   tmds_video_timing_ctrl #(
      .H_ACTIVE(M_HA), .H_FP(M_HFP), .H_SYNC(M_HS), .H_BP(M_HBP),
      .V_ACTIVE(M_VA), .V_FP(M_VFP), .V_SYNC(M_VS), .V_BP(M_VBP),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) u_main (
      .pixclk(pixclk), .rst(rst), .enable(m_en), .pix_req(m_req),
      .pix_x(m_x), .pix_y(m_y), .pix_rgb(m_rgb), .vd_r(m_r), .vd_g(m_g),
      .vd_b(m_b), .cd(m_cd), .vde(m_vde), .frame_start(m_fs),
      .busy(m_busy), .fsm_state(m_st)
   );

   tmds_video_timing_ctrl #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
   ) u_tiny (
      .pixclk(pixclk), .rst(rst), .enable(t_en), .pix_req(t_req),
      .pix_x(t_x), .pix_y(t_y), .pix_rgb(t_rgb), .vd_r(t_r), .vd_g(t_g),
      .vd_b(t_b), .cd(t_cd), .vde(t_vde), .frame_start(t_fs),
      .busy(t_busy), .fsm_state(t_st)
   );

   tmds_video_timing_ctrl u_def (
      .pixclk(pixclk), .rst(rst), .enable(d_en), .pix_req(d_req),
      .pix_x(d_x), .pix_y(d_y), .pix_rgb(d_rgb), .vd_r(d_r), .vd_g(d_g),
      .vd_b(d_b), .cd(d_cd), .vde(d_vde), .frame_start(d_fs),
      .busy(d_busy), .fsm_state(d_st)
   );

   // Frame sources: coordinate-coded pixel one cycle after a request,
   // random garbage otherwise.
   always @(posedge pixclk) begin
      m_rgb <= m_req ? {m_x[7:0], m_y[7:0], 8'hA5} : 24'($urandom);
      t_rgb <= t_req ? {t_x[7:0], t_y[7:0], 8'hA5} : 24'($urandom);
      d_rgb <= d_req ? {d_x[7:0], d_y[7:0], 8'hA5} : 24'($urandom);
   end

   // ---------------- checking helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model for u_main ----------------
   // phase 0 idle, 1 run, 2 drain; m_k is the cycle index inside the frame.
   int m_phase = 0;
   int m_k     = 0;
   int m_dleft = 0;
   // Scoreboard: {active, vsync, hsync, rgb} of the last two raster cycles.
   logic [26:0] exp_q[$];

   function automatic logic [26:0] m_entry();
      int h, v;
      logic a, hs, vs;
      logic [23:0] rgb;
      if (m_phase != 1) return 27'd0;
      h   = m_k % M_HT;
      v   = m_k / M_HT;
      a   = (h < M_HA) && (v < M_VA);
      hs  = (h >= M_HA + M_HFP) && (h < M_HA + M_HFP + M_HS);
      vs  = (v >= M_VA + M_VFP) && (v < M_VA + M_VFP + M_VS);
      rgb = a ? {8'(h), 8'(v), 8'hA5} : 24'd0;
      return {a, vs, hs, rgb};
   endfunction

   task automatic m_model_reset();
      m_phase = 0;
      m_k     = 0;
      m_dleft = 0;
      exp_q.delete();
      exp_q.push_back(27'd0);
      exp_q.push_back(27'd0);
   endtask

   task automatic main_check();
      logic [26:0] cur, old;
      int h, v;
      cur = m_entry();
      old = exp_q.pop_front();
      exp_q.push_back(cur);
      h = m_k % M_HT;
      v = m_k / M_HT;
      chk("m_pix_req", 32'(m_req), 32'(cur[26]));
      chk("m_pix_x", 32'(m_x), cur[26] ? 32'(h) : 32'd0);
      chk("m_pix_y", 32'(m_y), cur[26] ? 32'(v) : 32'd0);
      chk("m_frame_start", 32'(m_fs), 32'(m_phase == 1 && m_k == 0));
      chk("m_busy", 32'(m_busy), 32'(m_phase != 0));
      chk("m_vde", 32'(m_vde), 32'(old[26]));
      chk("m_cd", 32'(m_cd), 32'({~old[25], ~old[24]}));
      chk("m_vd", 32'({m_r, m_g, m_b}), 32'(old[23:0]));
   endtask

   task automatic main_advance();
      case (m_phase)
         0: if (m_en) begin m_phase = 1; m_k = 0; end
         1: begin
            if (m_k == M_FT - 1) begin
               m_k = 0;
               if (!m_en) begin m_phase = 2; m_dleft = 2; end
            end else begin
               m_k++;
            end
         end
         default: begin
            m_dleft--;
            if (m_dleft == 0) m_phase = 0;
         end
      endcase
   endtask

   task automatic main_cycle(input logic en_next);
      @(negedge pixclk);
      main_check();
      m_en = en_next;
      main_advance();
   endtask

   // ---------------- vector table for u_tiny ----------------
   typedef struct {
      int          k;
      logic        req;
      int          x;
      int          y;
      logic        fs;
      logic        vde;
      logic [1:0]  cd;
      logic [23:0] vd;
   } vec_t;

   vec_t tv[$];

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main test ----------------
   initial begin
      int idx;
      int t_vde_n, t_hs_n, t_vs_n;
      int d_vde_n, d_hlow_n, d_vlow_n, d_fs_n, d_bad_vd, d_bad_blank, p;
      int drain_n;
      logic prev_h;
      logic en_nx;
      int fall_q[$];

      // k = cycle since frame start; out = raster position k-2
      tv.push_back(vec_t'{0,  1, 0, 0, 1, 0, 2'b00, 24'h000000});
      tv.push_back(vec_t'{1,  1, 1, 0, 0, 0, 2'b00, 24'h000000});
      tv.push_back(vec_t'{2,  1, 2, 0, 0, 1, 2'b00, 24'h0000A5});
      tv.push_back(vec_t'{3,  1, 3, 0, 0, 1, 2'b00, 24'h0100A5});
      tv.push_back(vec_t'{4,  0, 0, 0, 0, 1, 2'b00, 24'h0200A5});
      tv.push_back(vec_t'{5,  0, 0, 0, 0, 1, 2'b00, 24'h0300A5});
      tv.push_back(vec_t'{6,  0, 0, 0, 0, 0, 2'b00, 24'h000000});
      tv.push_back(vec_t'{7,  0, 0, 0, 0, 0, 2'b01, 24'h000000});
      tv.push_back(vec_t'{8,  1, 0, 1, 0, 0, 2'b01, 24'h000000});
      tv.push_back(vec_t'{9,  1, 1, 1, 0, 0, 2'b00, 24'h000000});
      tv.push_back(vec_t'{10, 1, 2, 1, 0, 1, 2'b00, 24'h0001A5});
      tv.push_back(vec_t'{18, 1, 2, 2, 0, 1, 2'b00, 24'h0002A5});
      tv.push_back(vec_t'{21, 0, 0, 0, 0, 1, 2'b00, 24'h0302A5});
      tv.push_back(vec_t'{23, 0, 0, 0, 0, 0, 2'b01, 24'h000000});
      tv.push_back(vec_t'{26, 0, 0, 0, 0, 0, 2'b00, 24'h000000});
      tv.push_back(vec_t'{34, 0, 0, 0, 0, 0, 2'b10, 24'h000000});
      tv.push_back(vec_t'{39, 0, 0, 0, 0, 0, 2'b11, 24'h000000});
      tv.push_back(vec_t'{41, 1, 1, 5, 0, 0, 2'b10, 24'h000000});
      tv.push_back(vec_t'{42, 0, 0, 0, 0, 0, 2'b00, 24'h000000});
      tv.push_back(vec_t'{47, 0, 0, 0, 0, 0, 2'b01, 24'h000000});
      tv.push_back(vec_t'{48, 1, 0, 0, 1, 0, 2'b01, 24'h000000});
      tv.push_back(vec_t'{50, 1, 2, 0, 0, 1, 2'b00, 24'h0000A5});
      // row 5 is back porch, so k=41 has no request
      tv[17].req = 1'b0;
      tv[17].x   = 0;
      tv[17].y   = 0;

      m_model_reset();

      // ---- reset values ----
      repeat (3) @(negedge pixclk);
      chk("rst_vde", 32'(m_vde), 32'd0);
      chk("rst_cd", 32'(m_cd), 32'd3);
      chk("rst_cd_tiny", 32'(t_cd), 32'd0);
      chk("rst_pix_req", 32'(m_req), 32'd0);
      chk("rst_vd", 32'({m_r, m_g, m_b}), 32'd0);
      chk("rst_frame_start", 32'(m_fs), 32'd0);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_state", 32'(m_st), 32'(ST_IDLE));
      rst = 1'b0;

      // ---- tiny vectors and default-timing measurements ----
      @(negedge pixclk);
      t_en = 1'b1;
      d_en = 1'b1;
      idx = 0;
      t_vde_n = 0; t_hs_n = 0; t_vs_n = 0;
      d_vde_n = 0; d_hlow_n = 0; d_vlow_n = 0; d_fs_n = 0;
      d_bad_vd = 0; d_bad_blank = 0;
      prev_h = 1'b1;
      for (int k = 0; k < 1700; k++) begin
         @(negedge pixclk);
         if (idx < tv.size() && tv[idx].k == k) begin
            chk($sformatf("t%0d_req", k), 32'(t_req), 32'(tv[idx].req));
            chk($sformatf("t%0d_x", k), 32'(t_x), 32'(tv[idx].x));
            chk($sformatf("t%0d_y", k), 32'(t_y), 32'(tv[idx].y));
            chk($sformatf("t%0d_fs", k), 32'(t_fs), 32'(tv[idx].fs));
            chk($sformatf("t%0d_vde", k), 32'(t_vde), 32'(tv[idx].vde));
            chk($sformatf("t%0d_cd", k), 32'(t_cd), 32'(tv[idx].cd));
            chk($sformatf("t%0d_vd", k), 32'({t_r, t_g, t_b}), 32'(tv[idx].vd));
            idx++;
         end
         if (k >= 2 && k < 50) begin
            t_vde_n += int'(t_vde);
            t_hs_n  += int'(t_cd[CD_HSYNC]);
            t_vs_n  += int'(t_cd[CD_VSYNC]);
         end

         if (k == 0) chk("d_frame_start_first", 32'(d_fs), 32'd1);
         if (k == 1) chk("d_vde_before_first", 32'(d_vde), 32'd0);
         if (k == 2) begin
            chk("d_vde_first", 32'(d_vde), 32'd1);
            chk("d_vd_first", 32'({d_r, d_g, d_b}), 32'h0000A5);
         end
         d_fs_n += int'(d_fs);
         if (prev_h && !d_cd[CD_HSYNC]) fall_q.push_back(k);
         prev_h = d_cd[CD_HSYNC];
         if (k >= 2 && k < 802) begin
            d_vde_n  += int'(d_vde);
            d_hlow_n += int'(!d_cd[CD_HSYNC]);
         end
         d_vlow_n += int'(!d_cd[CD_VSYNC]);
         p = k - 2;
         if (d_vde) begin
            if ({d_r, d_g, d_b} != {8'(p % 800), 8'(p / 800), 8'hA5}) d_bad_vd++;
         end else if ({d_r, d_g, d_b} != 24'd0) begin
            d_bad_blank++;
         end
      end
      chk("t_table_entries_used", 32'(idx), 32'(tv.size()));
      chk("t_vde_per_frame", 32'(t_vde_n), 32'd12);
      chk("t_hsync_per_frame", 32'(t_hs_n), 32'd12);
      chk("t_vsync_per_frame", 32'(t_vs_n), 32'd8);
      chk("d_hsync_edges", 32'(fall_q.size()), 32'd2);
      if (fall_q.size() >= 2) begin
         chk("d_hsync_first_edge", 32'(fall_q[0]), 32'd658);
         chk("d_line_period", 32'(fall_q[1] - fall_q[0]), 32'd800);
      end
      chk("d_vde_line0", 32'(d_vde_n), 32'd640);
      chk("d_hsync_width", 32'(d_hlow_n), 32'd96);
      chk("d_vsync_lines01", 32'(d_vlow_n), 32'd0);
      chk("d_frame_start_count", 32'(d_fs_n), 32'd1);
      chk("d_vd_coord", 32'(d_bad_vd), 32'd0);
      chk("d_vd_blank_zero", 32'(d_bad_blank), 32'd0);
      t_en = 1'b0;
      d_en = 1'b0;

      // ---- main: idle cycles, then drop enable at line 3 ----
      repeat (3) main_cycle(1'b0);
      for (int i = 0; i < 73; i++) main_cycle(1'b1);
      drain_n = 0;
      for (int i = 0; i < M_FT - 72 + 6; i++) begin
         main_cycle(1'b0);
         if (m_st == ST_DRAIN) drain_n++;
      end
      chk("m_drain_cycles", 32'(drain_n), 32'd2);
      chk("m_idle_after_drain", 32'(m_st), 32'(ST_IDLE));
      chk("m_idle_cd", 32'(m_cd), 32'd3);
      chk("m_idle_busy", 32'(m_busy), 32'd0);

      // ---- main: reset mid-frame at h=10, v=4 ----
      for (int i = 0; i < 1 + 106; i++) main_cycle(1'b1);
      @(negedge pixclk);
      main_check();
      rst = 1'b1;
      #1;
      chk("m_midrst_vde", 32'(m_vde), 32'd0);
      chk("m_midrst_cd", 32'(m_cd), 32'd3);
      chk("m_midrst_pix_req", 32'(m_req), 32'd0);
      chk("m_midrst_vd", 32'({m_r, m_g, m_b}), 32'd0);
      chk("m_midrst_busy", 32'(m_busy), 32'd0);
      m_model_reset();
      repeat (2) @(negedge pixclk);
      main_check();
      rst  = 1'b0;
      m_en = 1'b1;
      main_advance();
      for (int i = 0; i < 2 * M_FT; i++) main_cycle(1'b1);

      // ---- main: randomized enable toggling ----
      en_nx = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 99) < 3) en_nx = ~en_nx;
         main_cycle(en_nx);
      end
      for (int i = 0; i < M_FT + 10; i++) main_cycle(1'b0);
      chk("m_final_idle", 32'(m_st), 32'(ST_IDLE));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
